vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates the 640x480@60 Hz raster timing that every pixel-painting block consumes: hCount, vCount, bright, hSync, vSync.
- Divides the 100 MHz board clock to a 25 MHz pixel-enable internally.
- Emits a once-per-frame tick that drives the slow game-update logic (character position, level state).
- Sits between the board clock/reset and the block controller / VGA connector.

Parameters:
- CLK_DIV, 4, board clocks per pixel; legal values are 1 or greater.
- H_TOTAL, 800, pixel clocks per line.
- H_SYNC, 96, hSync low width, starting at hCount 0.
- H_VIS_START, 144, first visible hCount.
- H_VIS_END, 783, last visible hCount (inclusive).
- V_TOTAL, 525, lines per frame.
- V_SYNC, 2, vSync low width in lines, starting at vCount 0.
- V_VIS_START, 35, first visible vCount.
- V_VIS_END, 514, last visible vCount (inclusive).

Ports:
- clk  input  1  board clock, 100 MHz; the only clock.
- rst  input  1  asynchronous, active-low reset; rst=0 resets.
- pix_en  output  1  high in the clk cycle before each counter step.
- hCount  output  10  horizontal position, 0..H_TOTAL-1.
- vCount  output  10  vertical position, 0..V_TOTAL-1.
- hSync  output  1  active-low horizontal sync.
- vSync  output  1  active-low vertical sync.
- bright  output  1  high when (hCount,vCount) is in the visible window.
- frame_tick  output  1  one-clk pulse when the counters reach (0,0) by wrap.

Behaviour:
- Reset (rst=0, async, effective without a clock edge) clears the divider, hCount, vCount, bright, frame_tick and pix_en to 0. hSync and vSync are also 0, which is consistent with position (0,0) lying inside both sync pulses.
- The divider div_cnt counts 0..CLK_DIV-1 every clk and wraps to 0. pix_en = (div_cnt==CLK_DIV-1), decoded from the register. With CLK_DIV=1, pix_en is constantly 1 out of reset.
- On a clk edge where pix_en=1, the counters step:
  - hCount increments; at H_TOTAL-1 it wraps to 0 and vCount increments.
  - vCount at V_TOTAL-1, when hCount also wraps, goes to 0.
  - On any edge where pix_en=0, the counters hold.
- The first step after reset release is on the CLK_DIV-th rising edge, where hCount goes 0->1.
- hSync, vSync and bright are registered and updated on the same edge as the counters, so they always describe the hCount/vCount currently presented. There is zero relative latency and no combinational glitches.
  - hSync = 0 iff hCount < H_SYNC.
  - vSync = 0 iff vCount < V_SYNC.
  - bright = 1 iff H_VIS_START<=hCount<=H_VIS_END and V_VIS_START<=vCount<=V_VIS_END.
- frame_tick is registered and high for exactly one clk cycle: the cycle in which the counters first show (0,0) after the (H_TOTAL-1,V_TOTAL-1) wrap. It is 0 otherwise, including the (0,0) state produced by reset.
- Counter widths: 10 bits. Arithmetic never exceeds 799, so there is no overflow path.
- Periods at default parameters:
  - Line: 3200 clk.
  - Frame: 1,680,000 clk (420,000 pixels x 4).
  - frame_tick rate: about 59.5 Hz.
- Reset asserted mid-frame aborts the frame immediately. After release, timing restarts exactly as from power-up and no frame_tick is issued for the aborted frame.
- Outputs hold stable between pix_en steps. Downstream logic may sample at clk or gate with pix_en.

Test Plan:
- Reset values: hold rst=0 for 10 clk, then release. All outputs read 0 before the first edge. hCount becomes 1 on edge 4, 2 on edge 8. pix_en is high on clk cycles 3, 7, 11, ...
- hSync line timing: observe a full line. hSync=0 for hCount 0..95, 1 for hCount 96..799. The next line starts 3200 clk after the previous one, and vCount increments exactly on the 799->0 hCount transition.
- bright window:
  - bright=1 at (144,35), (783,35), (144,514) and (783,514).
  - bright=0 at (143,35), (784,35), (144,34) and (144,515).
  - No X values on any of these.
- Frame wrap and vSync:
  - vSync=0 only for vCount 0..1.
  - (799,524) steps to (0,0) with frame_tick=1 for exactly 1 clk.
  - Consecutive frame_tick pulses are 1,680,000 clk apart, and there is no pulse after the initial reset.
- Async mid-frame reset: drive rst low at (400,300) between clock edges. All outputs go to 0 before the next edge. After release, timing matches the first scenario and the next frame_tick arrives at 1,680,000 clk.
- CLK_DIV=1 build: pix_en is constantly 1, hCount increments every clk, and the frame period is 420,000 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (counters, syncs, bright) with an internal
// pixel-enable divider and a once-per-frame tick, all registered off the board clock.
module vga_timing_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 514
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frame_tick
);
    localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_SW    = 10'(H_SYNC);
    localparam logic [9:0]    V_SW    = 10'(V_SYNC);
    localparam logic [9:0]    H_VS    = 10'(H_VIS_START);
    localparam logic [9:0]    H_VE    = 10'(H_VIS_END);
    localparam logic [9:0]    V_VS    = 10'(V_VIS_START);
    localparam logic [9:0]    V_VE    = 10'(V_VIS_END);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]    h_cnt_q, h_cnt_d;
    logic [9:0]    v_cnt_q, v_cnt_d;
    logic          pix_en_q, pix_en_d;
    logic          h_sync_q, h_sync_d;
    logic          v_sync_q, v_sync_d;
    logic          bright_q, bright_d;
    logic          frame_tick_q, frame_tick_d;
    logic          step;
    logic          h_wrap;

    // Syncs and bright decode the next counter values so they land on the same edge as the counters.
    always_comb begin
        step         = div_cnt_q == DIV_MAX;
        h_wrap       = h_cnt_q == H_MAX;
        div_cnt_d    = step ? '0 : div_cnt_q + DW'(1);
        pix_en_d     = div_cnt_d == DIV_MAX;
        h_cnt_d      = step ? (h_wrap ? '0 : h_cnt_q + 10'd1) : h_cnt_q;
        v_cnt_d      = (step && h_wrap) ? ((v_cnt_q == V_MAX) ? '0 : v_cnt_q + 10'd1) : v_cnt_q;
        h_sync_d     = h_cnt_d >= H_SW;
        v_sync_d     = v_cnt_d >= V_SW;
        bright_d     = (h_cnt_d >= H_VS) && (h_cnt_d <= H_VE) && (v_cnt_d >= V_VS) && (v_cnt_d <= V_VE);
        frame_tick_d = step && h_wrap && (v_cnt_q == V_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q    <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            pix_en_q     <= 1'b0;
            h_sync_q     <= 1'b0;
            v_sync_q     <= 1'b0;
            bright_q     <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            pix_en_q     <= pix_en_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            bright_q     <= bright_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pix_en     = pix_en_q;
    assign hCount     = h_cnt_q;
    assign vCount     = v_cnt_q;
    assign hSync      = h_sync_q;
    assign vSync      = v_sync_q;
    assign bright     = bright_q;
    assign frame_tick = frame_tick_q;
endmodule
